// File: rtl/iir_pkg.sv
// Shared constants and state encoding for the time-multiplexed IIR MAC core.
package iir_pkg;

    localparam int N_B        = 4;
    localparam int N_A        = 6;
    localparam int B_W        = 12;
    localparam int A_W        = 15;
    localparam int FRAC       = 12;
    localparam int DATA_W_DEF = 16;
    localparam int ACC_W_DEF  = 36;
    localparam int N_TAPS     = N_B + N_A;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_ROUND = 2'd2,
        S_OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/iir_round_sat.sv
// Combinational round-half-up and saturate from the Q.12 accumulator to an output sample.
module iir_round_sat
    import iir_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] y
);

    localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(2 ** (FRAC - 1));
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

    logic signed [ACC_W-1:0] biased;
    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        biased  = acc + HALF;
        shifted = biased >>> FRAC;
        if (shifted > Y_MAX) begin
            y = Y_MAX[DATA_W-1:0];
        end else if (shifted < Y_MIN) begin
            y = Y_MIN[DATA_W-1:0];
        end else begin
            y = shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/iir_mac_core.sv
// IIR filter core: one shared multiplier walks 4 feedforward and 6 feedback taps per sample.
//   state   | meaning
//   S_IDLE  | waiting for an input sample, in_ready high
//   S_MAC   | one product per cycle, tap index 0..9
//   S_ROUND | round/saturate accumulator, update histories
//   S_OUT   | output valid, held until out_ready
module iir_mac_core
    import iir_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic signed [B_W-1:0]    b_c [0:N_B-1],
    input  logic signed [A_W-1:0]    a_c [0:N_A-1],
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data
);

    localparam int PROD_W = A_W + DATA_W;

    state_e                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [3:0]                tap_q, tap_d;
    logic signed [DATA_W-1:0]  x_cur_q, x_cur_d;
    logic signed [DATA_W-1:0]  x_hist_q [0:N_B-2];
    logic signed [DATA_W-1:0]  x_hist_d [0:N_B-2];
    logic signed [DATA_W-1:0]  y_hist_q [0:N_A-1];
    logic signed [DATA_W-1:0]  y_hist_d [0:N_A-1];
    logic signed [DATA_W-1:0]  out_data_q, out_data_d;
    logic                      in_ready_q, in_ready_d;

    logic signed [DATA_W-1:0]  x_win [0:N_B-1];
    logic signed [A_W-1:0]     mul_a;
    logic signed [DATA_W-1:0]  mul_b;
    logic                      is_b_tap;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   term;
    logic signed [DATA_W-1:0]  rs_y;

    iir_round_sat #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W)
    ) u_round_sat (
        .acc (acc_q),
        .y   (rs_y)
    );

    // Operand mux: b taps see x[n..n-3], a taps see y[n-1..n-6].
    always_comb begin
        x_win[0] = x_cur_q;
        for (int k = 1; k < N_B; k++) begin
            x_win[k] = x_hist_q[k-1];
        end
        mul_a    = '0;
        mul_b    = '0;
        is_b_tap = 1'b0;
        for (int k = 0; k < N_B; k++) begin
            if (tap_q == 4'(k)) begin
                mul_a    = A_W'(b_c[k]);
                mul_b    = x_win[k];
                is_b_tap = 1'b1;
            end
        end
        for (int k = 0; k < N_A; k++) begin
            if (tap_q == 4'(N_B + k)) begin
                mul_a = a_c[k];
                mul_b = y_hist_q[k];
            end
        end
        prod     = mul_a * mul_b;
        prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        // b products carry 11 fractional bits; align to the accumulator's 12.
        term     = is_b_tap ? (prod_ext <<< 1) : prod_ext;
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        tap_d      = tap_q;
        x_cur_d    = x_cur_q;
        x_hist_d   = x_hist_q;
        y_hist_d   = y_hist_q;
        out_data_d = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_cur_d = in_data;
                    acc_d   = '0;
                    tap_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + term;
                if (tap_q == 4'(N_TAPS - 1)) begin
                    state_d = S_ROUND;
                end else begin
                    tap_d = tap_q + 4'd1;
                end
            end
            S_ROUND: begin
                out_data_d  = rs_y;
                x_hist_d[0] = x_cur_q;
                for (int k = 1; k < N_B - 1; k++) begin
                    x_hist_d[k] = x_hist_q[k-1];
                end
                y_hist_d[0] = rs_y;
                for (int k = 1; k < N_A; k++) begin
                    y_hist_d[k] = y_hist_q[k-1];
                end
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            tap_q      <= '0;
            x_cur_q    <= '0;
            x_hist_q   <= '{default: '0};
            y_hist_q   <= '{default: '0};
            out_data_q <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            tap_q      <= tap_d;
            x_cur_q    <= x_cur_d;
            x_hist_q   <= x_hist_d;
            y_hist_q   <= y_hist_d;
            out_data_q <= out_data_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == S_OUT);
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_iir_mac_core.sv
// Self-checking bench for iir_mac_core against an arithmetic model of the filter equation.
module tb_iir_mac_core;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic signed [11:0] b_c [0:3];
    logic signed [14:0] a_c [0:5];
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;

    int tests_run    = 0;
    int tests_failed = 0;

    int xh [0:2];
    int yh [0:5];
    logic signed [15:0] last_y;

    iir_mac_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .b_c       (b_c),
        .a_c       (a_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int k = 0; k < 3; k++) xh[k] = 0;
        for (int k = 0; k < 6; k++) yh[k] = 0;
    endfunction

    // y = sum b*x (Q.11, doubled to Q.12) + sum a*y (Q.12), round half up, saturate.
    function automatic int model_step(input int x);
        longint acc;
        longint r;
        int     xw [0:3];
        xw[0] = x;
        for (int k = 1; k < 4; k++) xw[k] = xh[k-1];
        acc = 0;
        for (int k = 0; k < 4; k++) acc += 2 * longint'(b_c[k]) * longint'(xw[k]);
        for (int k = 0; k < 6; k++) acc += longint'(a_c[k]) * longint'(yh[k]);
        r = (acc + 2048) >>> 12;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        for (int k = 2; k > 0; k--) xh[k] = xh[k-1];
        xh[0] = x;
        for (int k = 5; k > 0; k--) yh[k] = yh[k-1];
        yh[0] = int'(r);
        return int'(r);
    endfunction

    task automatic set_coeffs(input int b0, input int b1, input int b2, input int b3, input int a0);
        b_c[0] = 12'(b0); b_c[1] = 12'(b1); b_c[2] = 12'(b2); b_c[3] = 12'(b3);
        a_c[0] = 15'(a0);
        for (int k = 1; k < 6; k++) a_c[k] = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        model_clear();
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) begin
            tests_run++; tests_failed++;
            $display("FAIL %s in_ready timeout: in_ready=%b, required 1", name, in_ready);
        end
    endtask

    // Full sample transaction with out_ready held high; checks latency, data, and release.
    task automatic do_sample(input logic signed [15:0] x, input string name);
        int cyc;
        int exp_y;
        wait_ready(name);
        in_valid = 1'b1;
        in_data  = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_y = model_step(int'(x));
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        tests_run++;
        if (cyc != 12) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d cycles, required 12", name, cyc);
        end
        tests_run++;
        if (out_data !== 16'(exp_y)) begin
            tests_failed++;
            $display("FAIL %s data: got %0d, required %0d (x=%0d)", name, out_data, exp_y, x);
        end
        last_y = out_data;
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s release: out_valid=%b in_ready=%b, required 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        set_coeffs(0, 0, 0, 0, 0);
        model_clear();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'sd0) begin
                tests_failed++;
                $display("FAIL reset_hold: in_ready=%b out_valid=%b out_data=%0d, required 0/0/0",
                         in_ready, out_valid, out_data);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'sd0) begin
            tests_failed++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b out_data=%0d, required 1/0/0",
                     in_ready, out_valid, out_data);
        end
    endtask

    task automatic test_gain();
        apply_reset();
        set_coeffs(1024, 0, 0, 0, 0);
        do_sample(16'sd1000, "gain");
        tests_run++;
        if (last_y !== 16'sd500) begin
            tests_failed++;
            $display("FAIL gain_const: got %0d, required 500", last_y);
        end
    endtask

    task automatic test_recursion();
        int exp_c [0:2] = '{2000, 1000, 500};
        int xs    [0:2] = '{4000, 0, 0};
        apply_reset();
        set_coeffs(1024, 0, 0, 0, 2048);
        for (int i = 0; i < 3; i++) begin
            do_sample(16'(xs[i]), "recursion");
            tests_run++;
            if (last_y !== 16'(exp_c[i])) begin
                tests_failed++;
                $display("FAIL recursion_const[%0d]: got %0d, required %0d", i, last_y, exp_c[i]);
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        set_coeffs(2047, 2047, 2047, 2047, 0);
        for (int i = 0; i < 4; i++) do_sample(16'sd32767, "sat_pos");
        tests_run++;
        if (last_y !== 16'sd32767) begin
            tests_failed++;
            $display("FAIL sat_pos_const: got %0d, required 32767", last_y);
        end
        for (int i = 0; i < 4; i++) do_sample(-16'sd32768, "sat_neg");
        tests_run++;
        if (last_y !== -16'sd32768) begin
            tests_failed++;
            $display("FAIL sat_neg_const: got %0d, required -32768", last_y);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int exp_y;
        logic signed [15:0] held;
        apply_reset();
        set_coeffs(700, -300, 200, 100, 1500);
        do_sample(16'sd3000, "bp_pre");
        out_ready = 1'b0;
        wait_ready("bp");
        in_valid = 1'b1;
        in_data  = -16'sd1234;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_y = model_step(-1234);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        held = out_data;
        tests_run++;
        if (n >= 40 || held !== 16'(exp_y)) begin
            tests_failed++;
            $display("FAIL bp_data: got %0d valid=%b, required %0d", held, out_valid, exp_y);
        end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== held) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b out_data=%0d, required 1/0/%0d",
                         c, out_valid, in_ready, out_data, held);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
        do_sample(16'sd500, "bp_post");
        do_sample(16'sd0, "bp_post2");
    endtask

    task automatic test_reset_mid_mac();
        int n;
        apply_reset();
        set_coeffs(1024, 0, 0, 0, 0);
        do_sample(16'sd1000, "mid_pre");
        wait_ready("mid");
        in_valid = 1'b1;
        in_data  = 16'sd2222;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b, required 0/0", out_valid, in_ready);
        end
        rst_n = 1'b1;
        model_clear();
        n = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) n++;
        end
        tests_run++;
        if (n != 0) begin
            tests_failed++;
            $display("FAIL mid_no_out: out_valid high for %0d cycles, required 0", n);
        end
        set_coeffs(0, 2047, 0, 0, 0);
        do_sample(16'sd1000, "mid_post");
        tests_run++;
        if (last_y !== 16'sd0) begin
            tests_failed++;
            $display("FAIL mid_hist_clear: got %0d, required 0", last_y);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 4; k++) b_c[k] = 12'($urandom);
        for (int k = 0; k < 6; k++) a_c[k] = 15'(int'($urandom_range(0, 2047)) - 1024);
        for (int i = 0; i < 20; i++) do_sample(16'($urandom), "random");
        for (int k = 0; k < 6; k++) a_c[k] = 15'($urandom);
        for (int i = 0; i < 10; i++) do_sample(16'($urandom), "random_wide");
    endtask

    initial begin
        test_reset();
        test_gain();
        test_recursion();
        test_saturation();
        test_backpressure();
        test_reset_mid_mac();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
